imem_loader: RTL and testbench

Program loader that writes the instruction memory from a byte stream before the LEGv8 core runs. It is the write-side counterpart of the core's instruction fetch path. It accepts a length-prefixed little-endian byte stream, assembles 32-bit instruction words, and drives the instruction-memory write port at byte addresses 0, 4, 8, … It holds the core in reset until the program is fully written.

---
 rtl/legv8_pkg.sv | 18 +
 rtl/byte_packer.sv | 30 +++
 rtl/imem_loader.sv | 126 ++++++++++++
 tb/tb_imem_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: instruction geometry and the program-loader state encoding.
package legv8_pkg;
  localparam int INSTR_W         = 32;
  localparam int BYTES_PER_INSTR = 4;

  typedef enum logic [2:0] {
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_WRITE,
    ST_DONE
  } loader_state_t;

  // Word index to byte address; the fetch path walks the same 4-byte stride.
  function automatic logic [17:0] word_byte_addr(input logic [15:0] idx);
    return {idx, 2'b00};
  endfunction
endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into instruction words: first byte lands in [7:0].
module byte_packer
  import legv8_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         byte_data,
  input  logic               byte_strobe,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word
);
  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_INSTR - 1);

  logic [1:0]         byte_idx;
  logic [INSTR_W-9:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx <= '0;
      sr       <= '0;
    end else if (byte_strobe) begin
      byte_idx <= byte_idx + 2'd1;
      sr       <= {byte_data, sr[INSTR_W-9:8]};
    end
  end

  // The last byte completes the word combinationally so the write can be registered next edge.
  assign word_valid = byte_strobe && (byte_idx == LAST_IDX);
  assign word       = {byte_data, sr};
endmodule

// File: rtl/imem_loader.sv
// Loads instruction memory from a length-prefixed byte stream and holds the core until done.
//
// state    | meaning
// HDR0     | waiting for word count low byte
// HDR1     | waiting for word count high byte
// DATA     | collecting payload bytes into the next word
// WRITE    | one-cycle memory write strobe, stream paused
// DONE     | load finished, core released, waits for start
module imem_loader
  import legv8_pkg::*;
#(
  parameter int IM_WORDS = 64,
  parameter int ADDR_W   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               start,
  output logic               im_wr_en,
  output logic [ADDR_W-1:0]  im_wr_addr,
  output logic [INSTR_W-1:0] im_wr_data,
  output logic               cpu_hold,
  output logic               done,
  output logic               overflow
);
  localparam logic [16:0] IM_WORDS_L = 17'(IM_WORDS);

  loader_state_t      state;
  logic [7:0]         cnt_lo;
  logic [15:0]        n_total;
  logic [16:0]        wr_limit;
  logic [15:0]        word_idx;
  logic [15:0]        idx_next;
  logic [15:0]        hdr_count;
  logic               xfer;
  logic               pk_strobe;
  logic               word_valid;
  logic [INSTR_W-1:0] word;

  assign xfer      = in_valid && in_ready;
  assign pk_strobe = xfer && (state == ST_DATA);
  assign hdr_count = {in_data, cnt_lo};
  assign idx_next  = word_idx + 16'd1;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_data  (in_data),
    .byte_strobe(pk_strobe),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_HDR0;
      cnt_lo     <= '0;
      n_total    <= '0;
      wr_limit   <= '0;
      word_idx   <= '0;
      in_ready   <= 1'b1;
      cpu_hold   <= 1'b1;
      im_wr_en   <= 1'b0;
      im_wr_addr <= '0;
      im_wr_data <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done     <= 1'b0;
      im_wr_en <= 1'b0;
      case (state)
        ST_HDR0: if (xfer) begin
          cnt_lo <= in_data;
          state  <= ST_HDR1;
        end
        ST_HDR1: if (xfer) begin
          n_total <= hdr_count;
          if (hdr_count == 16'd0) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            in_ready <= 1'b0;
          end else begin
            // Oversized programs are still drained; only the write limit is clamped.
            if ({1'b0, hdr_count} > IM_WORDS_L) begin
              overflow <= 1'b1;
              wr_limit <= IM_WORDS_L;
            end else begin
              wr_limit <= {1'b0, hdr_count};
            end
            state <= ST_DATA;
          end
        end
        ST_DATA: if (word_valid) begin
          state    <= ST_WRITE;
          in_ready <= 1'b0;
          if ({1'b0, word_idx} < wr_limit) begin
            im_wr_en   <= 1'b1;
            im_wr_addr <= ADDR_W'(word_byte_addr(word_idx));
            im_wr_data <= word;
          end
        end
        ST_WRITE: begin
          word_idx <= idx_next;
          if (idx_next == n_total) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state    <= ST_DATA;
            in_ready <= 1'b1;
          end
        end
        ST_DONE: if (start) begin
          state    <= ST_HDR0;
          word_idx <= '0;
          in_ready <= 1'b1;
          cpu_hold <= 1'b1;
        end
        default: state <= ST_HDR0;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench: a default-depth loader and a 2-word loader share one input stream.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset, in_valid, start;
  logic [7:0]  in_data;
  logic        in_ready, im_wr_en, cpu_hold, done, overflow;
  logic [63:0] im_wr_addr;
  logic [31:0] im_wr_data;
  logic        ov_in_ready, ov_im_wr_en, ov_cpu_hold, ov_done, ov_overflow;
  logic [63:0] ov_im_wr_addr;
  logic [31:0] ov_im_wr_data;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt, ov_done_cnt, done_cyc;
  logic [63:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic [63:0] ov_addr_q[$];
  logic [31:0] ov_data_q[$];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .start(start), .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr), .im_wr_data(im_wr_data),
    .cpu_hold(cpu_hold), .done(done), .overflow(overflow)
  );

  imem_loader #(.IM_WORDS(2)) dut_ov (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(ov_in_ready),
    .start(start), .im_wr_en(ov_im_wr_en), .im_wr_addr(ov_im_wr_addr), .im_wr_data(ov_im_wr_data),
    .cpu_hold(ov_cpu_hold), .done(ov_done), .overflow(ov_overflow)
  );

  always @(negedge clk) begin
    cyc++;
    if (im_wr_en) begin
      wr_addr_q.push_back(im_wr_addr);
      wr_data_q.push_back(im_wr_data);
      wr_cyc_q.push_back(cyc);
    end
    if (ov_im_wr_en) begin
      ov_addr_q.push_back(ov_im_wr_addr);
      ov_data_q.push_back(ov_im_wr_data);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ov_done) ov_done_cnt++;
  end

  task automatic clear_log();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    ov_addr_q.delete(); ov_data_q.delete();
    done_cnt = 0; ov_done_cnt = 0; done_cyc = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge right after the byte transferred.
  task automatic push(input logic [7:0] b);
    int t = 0;
    in_data = b; in_valid = 1'b1;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    n_checks++;
    if (t >= 50) $display("FAIL push_timeout byte=%h in_ready stuck at %b, required 1", b, in_ready);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 200) begin @(negedge clk); t++; end
    n_checks++;
    if (t >= 200) $display("FAIL done_timeout done=%b after %0d cycles, required 1", done, t);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_ready, cpu_hold, im_wr_en, done, overflow} !== 5'b11000)
      $display("FAIL reset_flags got rdy/hold/wr/done/ovf=%b required 11000",
               {in_ready, cpu_hold, im_wr_en, done, overflow});
    else n_pass++;
    n_checks++;
    if (im_wr_addr !== 64'd0 || im_wr_data !== 32'd0)
      $display("FAIL reset_port got addr=%h data=%h required 0/0", im_wr_addr, im_wr_data);
    else n_pass++;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready, cpu_hold, done} !== 3'b110)
      $display("FAIL reset_release got rdy/hold/done=%b required 110", {in_ready, cpu_hold, done});
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset(); clear_log();
    push(8'h01); push(8'h00); push(8'h20); push(8'h04); push(8'h00); push(8'h91);
    n_checks++;
    if (im_wr_en !== 1'b1 || im_wr_addr !== 64'd0 || im_wr_data !== 32'h91000420 || in_ready !== 1'b0)
      $display("FAIL single_write got en=%b addr=%h data=%h rdy=%b required 1/0/91000420/0",
               im_wr_en, im_wr_addr, im_wr_data, in_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({done, cpu_hold, in_ready, im_wr_en} !== 4'b1000)
      $display("FAIL single_done got done/hold/rdy/wr=%b required 1000", {done, cpu_hold, in_ready, im_wr_en});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || done_cnt !== 1 || wr_addr_q.size() !== 1)
      $display("FAIL single_pulse got done=%b done_cnt=%0d writes=%0d required 0/1/1",
               done, done_cnt, wr_addr_q.size());
    else n_pass++;
  endtask

  task automatic test_three_stalls();
    logic [7:0]  bytes [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                                8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    logic [31:0] exp_d [3] = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};
    do_reset(); clear_log();
    push(8'h03); push(8'h00);
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      push(bytes[i]);
    end
    wait_done();
    n_checks++;
    if (wr_addr_q.size() !== 3 || done_cnt !== 1)
      $display("FAIL three_count got writes=%0d done_cnt=%0d required 3/1", wr_addr_q.size(), done_cnt);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (wr_addr_q.size() <= i)
        $display("FAIL three_word%0d missing write, required addr=%0d data=%h", i, 4 * i, exp_d[i]);
      else if (wr_addr_q[i] !== 64'(4 * i) || wr_data_q[i] !== exp_d[i])
        $display("FAIL three_word%0d got addr=%0d data=%h required addr=%0d data=%h",
                 i, wr_addr_q[i], wr_data_q[i], 4 * i, exp_d[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset(); clear_log();
    push(8'h02); push(8'h00);
    push(8'hEF); push(8'hBE); push(8'hAD); push(8'hDE);
    push(8'h0D); push(8'hF0); push(8'hFE); push(8'hCA);
    wait_done();
    n_checks++;
    if (wr_data_q.size() !== 2)
      $display("FAIL b2b_count got writes=%0d required 2", wr_data_q.size());
    else if (wr_data_q[0] !== 32'hDEADBEEF || wr_data_q[1] !== 32'hCAFEF00D || wr_addr_q[1] !== 64'd4)
      $display("FAIL b2b_data got %h,%h addr1=%0d required deadbeef,cafef00d addr1=4",
               wr_data_q[0], wr_data_q[1], wr_addr_q[1]);
    else n_pass++;
    n_checks++;
    if (wr_cyc_q.size() !== 2)
      $display("FAIL b2b_spacing got writes=%0d required 2", wr_cyc_q.size());
    else if (wr_cyc_q[1] - wr_cyc_q[0] !== 5 || done_cyc - wr_cyc_q[1] !== 1)
      $display("FAIL b2b_spacing got write gap=%0d done lag=%0d required 5/1",
               wr_cyc_q[1] - wr_cyc_q[0], done_cyc - wr_cyc_q[1]);
    else n_pass++;
  endtask

  task automatic test_empty();
    do_reset(); clear_log();
    push(8'h00); push(8'h00);
    n_checks++;
    if ({done, cpu_hold, in_ready} !== 3'b100)
      $display("FAIL empty_done got done/hold/rdy=%b required 100", {done, cpu_hold, in_ready});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (wr_addr_q.size() !== 0 || done_cnt !== 1)
      $display("FAIL empty_writes got writes=%0d done_cnt=%0d required 0/1", wr_addr_q.size(), done_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_midload();
    do_reset(); clear_log();
    push(8'h01); push(8'h00); push(8'h11); push(8'h22);
    do_reset();
    push(8'h01); push(8'h00); push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
    wait_done();
    n_checks++;
    if (wr_data_q.size() !== 1)
      $display("FAIL midload_count got writes=%0d required 1", wr_data_q.size());
    else if (wr_addr_q[0] !== 64'd0 || wr_data_q[0] !== 32'hDDCCBBAA)
      $display("FAIL midload_word got addr=%0d data=%h required 0/ddccbbaa", wr_addr_q[0], wr_data_q[0]);
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset(); clear_log();
    n_checks++;
    if (ov_overflow !== 1'b0)
      $display("FAIL ovf_cleared got %b required 0", ov_overflow);
    else n_pass++;
    push(8'h03); push(8'h00);
    n_checks++;
    if (ov_overflow !== 1'b1 || overflow !== 1'b0)
      $display("FAIL ovf_flag got small=%b big=%b required 1/0", ov_overflow, overflow);
    else n_pass++;
    for (int i = 1; i <= 12; i++) push(8'(i));
    wait_done();
    n_checks++;
    if (ov_addr_q.size() !== 2 || ov_done_cnt !== 1)
      $display("FAIL ovf_count got writes=%0d done_cnt=%0d required 2/1", ov_addr_q.size(), ov_done_cnt);
    else if (ov_addr_q[0] !== 64'd0 || ov_data_q[0] !== 32'h04030201 ||
             ov_addr_q[1] !== 64'd4 || ov_data_q[1] !== 32'h08070605)
      $display("FAIL ovf_words got %0d:%h %0d:%h required 0:04030201 4:08070605",
               ov_addr_q[0], ov_data_q[0], ov_addr_q[1], ov_data_q[1]);
    else n_pass++;
    n_checks++;
    if (wr_data_q.size() !== 3)
      $display("FAIL ovf_ref_count got writes=%0d required 3", wr_data_q.size());
    else if (wr_addr_q[2] !== 64'd8 || wr_data_q[2] !== 32'h0C0B0A09)
      $display("FAIL ovf_ref_word got addr=%0d data=%h required 8/0c0b0a09", wr_addr_q[2], wr_data_q[2]);
    else n_pass++;
  endtask

  task automatic test_rearm();
    n_checks++;
    if (cpu_hold !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL rearm_idle got hold=%b rdy=%b required 0/0", cpu_hold, in_ready);
    else n_pass++;
    clear_log();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (cpu_hold !== 1'b1 || in_ready !== 1'b1)
      $display("FAIL rearm_hold got hold=%b rdy=%b required 1/1", cpu_hold, in_ready);
    else n_pass++;
    push(8'h01); push(8'h00);
    start = 1'b1;
    push(8'h5A);
    start = 1'b0;
    push(8'hA5); push(8'h3C); push(8'hC3);
    wait_done();
    n_checks++;
    if (wr_data_q.size() !== 1 || done_cnt !== 1)
      $display("FAIL rearm_count got writes=%0d done_cnt=%0d required 1/1", wr_data_q.size(), done_cnt);
    else if (wr_addr_q[0] !== 64'd0 || wr_data_q[0] !== 32'hC33CA55A)
      $display("FAIL rearm_word got addr=%0d data=%h required 0/c33ca55a", wr_addr_q[0], wr_data_q[0]);
    else n_pass++;
    n_checks++;
    if (ov_overflow !== 1'b1 || cpu_hold !== 1'b0)
      $display("FAIL rearm_sticky got ovf=%b hold=%b required 1/0", ov_overflow, cpu_hold);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_three_stalls();
    test_back_to_back();
    test_empty();
    test_reset_midload();
    test_overflow();
    test_rearm();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, passed %0d of %0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
